// File: rtl/instr_defs_pkg.sv
// Shared CPU definitions: opcode encodings seen by the control sequencer.
// Any opcode not listed here is an ALU operation (execute, then write back).
package instr_defs_pkg;
  localparam logic [3:0] kBEQ  = 4'h8;
  localparam logic [3:0] kBNE  = 4'h9;
  localparam logic [3:0] kLW   = 4'hA;
  localparam logic [3:0] kSW   = 4'hB;
  localparam logic [3:0] kHALT = 4'hF;
endpackage

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM for the CPU core.
// Steps fetch/decode/execute/memory/writeback and drives the PC, register
// file and memory enables. It counts retired instructions with saturation,
// stops in HALT, and enters ERR when a memory access waits too long.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   leaves IDLE (only looked at in IDLE)
//   op[3:0]    in   opcode from the instruction register
//   z          in   ALU zero flag, used in EXEC for branches
//   mem_ack    in   memory acknowledge; completes a transfer in the same cycle
//   mem_req    out  memory request (FETCH, MEM)
//   mem_we     out  memory write enable (MEM with a store)
//   ir_load    out  latch the fetched instruction
//   rf_we      out  register file write enable (WB)
//   pc_step    out  one-cycle pulse per retired instruction
//   pc_branch  out  take the relative branch; only asserted with pc_step
//   busy       out  high outside IDLE/HALT/ERR
//   halted     out  high in HALT
//   err        out  high in ERR
//   retired    out  saturating retired-instruction count
module instr_sequencer
  import instr_defs_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             z,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             rf_we,
  output logic             pc_step,
  output logic             pc_branch,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  // The wait counter only ever holds 0..TIMEOUT-1 before ERR is taken.
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [TO_W-1:0]   wait_reg, wait_next;
  logic [CNT_W-1:0]  retired_reg, retired_next;
  logic              timed_out;
  logic              is_mem_op;
  logic              is_branch;

  assign is_mem_op = (op == kLW) || (op == kSW);
  assign is_branch = (op == kBEQ) || (op == kBNE);
  // True on the TIMEOUT-th wait cycle; an ack in that same cycle still wins.
  assign timed_out = (wait_reg == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    rf_we      = 1'b0;
    pc_step    = 1'b0;
    pc_branch  = 1'b0;
    halted     = 1'b0;
    err        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_ERR;
        end
      end
      S_DECODE: begin
        state_next = (op == kHALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (is_mem_op) begin
          state_next = S_MEM;
        end else if (is_branch) begin
          // Branch resolves here; the PC unit decides taken/not-taken.
          pc_step    = 1'b1;
          pc_branch  = z;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == kSW);
        if (mem_ack) begin
          if (op == kSW) begin
            pc_step    = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timed_out) begin
          state_next = S_ERR;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        pc_step    = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   err    = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg != S_IDLE) && (state_reg != S_HALT) && (state_reg != S_ERR);

  // Any state change restarts the wait count, so FETCH and MEM always begin
  // their handshake at zero.
  always_comb begin
    wait_next = wait_reg;
    if (state_next != state_reg) begin
      wait_next = '0;
    end else if (mem_req && !mem_ack) begin
      wait_next = wait_reg + TO_W'(1);
    end
  end

  always_comb begin
    retired_next = retired_reg;
    if (pc_step && (retired_reg != {CNT_W{1'b1}})) begin
      retired_next = retired_reg + CNT_W'(1);
    end
  end

  assign retired = retired_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      wait_reg    <= '0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      retired_reg <= retired_next;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer. Each instruction is described by its
// opcode, fetch wait count, memory wait count and zero flag; the expected
// timeline (pc_step cycle, enables, counts) is computed from those numbers.
// A second instance with CNT_W=2 shares the inputs to exercise saturation.
module tb_instr_sequencer;
  import instr_defs_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, z, mem_ack;
  logic [3:0]  op;
  logic        mem_req, mem_we, ir_load, rf_we, pc_step, pc_branch, busy, halted, err;
  logic [15:0] retired;
  logic        s_mem_req, s_mem_we, s_ir_load, s_rf_we, s_pc_step, s_pc_branch;
  logic        s_busy, s_halted, s_err;
  logic [1:0]  s_retired;

  int n_tests = 0;
  int n_fail  = 0;
  int model_retired = 0;

  logic [3:0] alu_ops [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                               4'hC, 4'hD, 4'hE};

  always #5 clk = ~clk;

  instr_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .z(z), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .rf_we(rf_we),
    .pc_step(pc_step), .pc_branch(pc_branch), .busy(busy), .halted(halted),
    .err(err), .retired(retired)
  );

  instr_sequencer #(.CNT_W(2), .TIMEOUT(15)) u_sat (
    .clk(clk), .reset(reset), .start(start), .op(op), .z(z), .mem_ack(mem_ack),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .ir_load(s_ir_load), .rf_we(s_rf_we),
    .pc_step(s_pc_step), .pc_branch(s_pc_branch), .busy(s_busy), .halted(s_halted),
    .err(s_err), .retired(s_retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {23'd0, mem_req, mem_we, ir_load, rf_we, pc_step, pc_branch, busy, halted, err};
  endfunction

  function automatic int sat_exp();
    return (model_retired > 3) ? 3 : model_retired;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_retired(input string tag);
    check({tag, "_retired"}, retired, model_retired);
    check({tag, "_retired_sat"}, s_retired, sat_exp());
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; mem_ack = 1'b0; z = 1'b0; op = 4'($urandom);
    repeat (2) @(posedge clk);
    #1;
    model_retired = 0;
    check("reset_outs", outs_vec(), 0);
    check_retired("reset");
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    mem_ack = 1'($urandom);
    @(negedge clk);
    check("idle_outs", outs_vec(), 0);
    tick();
    start = 1'b0;
  endtask

  // Runs one instruction starting in its first FETCH cycle.
  task automatic run_instr(input logic [3:0] iop, input int fw, input int mw, input logic iz);
    bit mem_op = (iop == kLW) || (iop == kSW);
    bit br     = (iop == kBEQ) || (iop == kBNE);
    bit has_rf = !br && (iop != kSW);
    int exp_step;
    int step_at = 0, rf_at = 0, ir_at = 0;
    int n_step = 0, n_rf = 0, n_we = 0, n_req = 0, n_ir = 0, busy_low = 0, bad = 0;
    logic pcb_at = 1'b0;
    exp_step = br ? fw + 3 : (iop == kSW) ? fw + mw + 4 : (iop == kLW) ? fw + mw + 5 : fw + 4;
    for (int c = 1; c <= exp_step; c++) begin
      bit ack_cyc = (c == fw + 1) || (mem_op && c == fw + mw + 4);
      bit ign     = (c == fw + 2) || (c == fw + 3) || (has_rf && c == exp_step);
      mem_ack = ack_cyc ? 1'b1 : (ign ? 1'($urandom) : 1'b0);
      op      = (c <= fw + 1) ? 4'($urandom) : iop;
      z       = (c == fw + 3) ? iz : 1'($urandom);
      start   = 1'($urandom);
      @(negedge clk);
      if (c == 1) check_retired("instr_start");
      if (pc_step && step_at == 0) begin
        step_at = c;
        pcb_at  = pc_branch;
      end
      if (rf_we) rf_at = c;
      if (ir_load) begin
        n_ir++;
        ir_at = c;
      end
      n_step += int'(pc_step);
      n_rf   += int'(rf_we);
      n_we   += int'(mem_we);
      n_req  += int'(mem_req);
      if (!busy) busy_low++;
      if ((pc_branch && !pc_step) || (rf_we && mem_req) || halted || err) bad++;
      tick();
    end
    model_retired++;
    $display("[TB] op=%h fw=%0d mw=%0d z=%0d step@%0d (exp %0d) branch=%0d",
             iop, fw, mw, iz, step_at, exp_step, pcb_at);
    check("step_cycle", step_at, exp_step);
    check("step_count", n_step, 1);
    check("pc_branch", pcb_at, (br ? iz : 1'b0));
    check("rf_we_count", n_rf, has_rf ? 1 : 0);
    check("rf_we_cycle", rf_at, has_rf ? exp_step : 0);
    check("mem_we_cycles", n_we, (iop == kSW) ? mw + 1 : 0);
    check("mem_req_cycles", n_req, fw + 1 + (mem_op ? mw + 1 : 0));
    check("ir_load_cycle", ir_at, fw + 1);
    check("ir_load_count", n_ir, 1);
    check("busy_low", busy_low, 0);
    check("invariants", bad, 0);
  endtask

  task automatic run_halt(input int fw);
    int early = 0;
    for (int c = 1; c <= fw + 2; c++) begin
      mem_ack = (c == fw + 1) ? 1'b1 : (c == fw + 2) ? 1'($urandom) : 1'b0;
      op      = (c <= fw + 1) ? 4'($urandom) : kHALT;
      start   = 1'($urandom);
      @(negedge clk);
      if (c == 1) check_retired("halt_start");
      if (pc_step || halted || !busy) early++;
      tick();
    end
    check("halt_pre", early, 0);
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; mem_ack = 1'($urandom); op = 4'($urandom);
      @(negedge clk);
      check("halt_state", {27'd0, halted, busy, pc_step, mem_req, err}, 32'b10000);
      check_retired("halt");
      tick();
    end
    $display("[TB] halt fw=%0d retired=%0d sat=%0d", fw, retired, s_retired);
  endtask

  // fetch_hang: never ack the fetch; otherwise a store whose MEM never acks.
  task automatic run_timeout(input bit fetch_hang);
    int fw = fetch_hang ? 0 : int'($urandom_range(0, 3));
    int err_cycle = fetch_hang ? 16 : fw + 19;
    int early = 0;
    for (int c = 1; c <= err_cycle + 2; c++) begin
      mem_ack = (!fetch_hang && c == fw + 1) ? 1'b1 : (c >= err_cycle) ? 1'($urandom) : 1'b0;
      op      = kSW;
      start   = (c >= err_cycle) ? 1'b1 : 1'($urandom);
      @(negedge clk);
      if (c < err_cycle && (err || pc_step)) early++;
      if (c == err_cycle - 1) check("timeout_last_wait", {mem_req, err}, 2'b10);
      if (c >= err_cycle) check("timeout_err", {27'd0, err, busy, mem_req, pc_step, halted}, 32'b10000);
      tick();
    end
    check("timeout_early", early, 0);
    check_retired("timeout");
    $display("[TB] timeout fetch_hang=%0d err_cycle=%0d err=%0d", fetch_hang, err_cycle, err);
  endtask

  task automatic reset_mid_mem();
    for (int c = 1; c <= 4; c++) begin
      mem_ack = (c == 1); op = kLW; z = 1'b0; start = 1'b0;
      @(negedge clk);
      if (c == 1) check_retired("pre_reset");
      if (c < 4) tick();
    end
    check("mid_mem_req", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    model_retired = 0;
    check("async_reset_outs", outs_vec(), 0);
    check_retired("async_reset");
    tick();
    check("reset_held_outs", outs_vec(), 0);
    reset = 1'b1;
    $display("[TB] reset mid-MEM retired=%0d", retired);
  endtask

  function automatic logic [3:0] rand_op();
    int r = int'($urandom_range(0, 5));
    case (r)
      0: return kBEQ;
      1: return kBNE;
      2: return kLW;
      3: return kSW;
      default: return alu_ops[$urandom_range(0, 10)];
    endcase
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 4));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    do_start();
    run_instr(4'h1, 0, 0, 1'b0);
    run_instr(kBEQ, 0, 0, 1'b1);
    run_instr(kBNE, 0, 0, 1'b0);
    run_instr(kLW, 2, 3, 1'b0);
    run_instr(kSW, 0, 0, 1'b1);
    run_instr(kLW, 14, 14, 1'b0);
    run_instr(kSW, 14, 14, 1'b0);
    for (int i = 0; i < 40; i++) begin
      run_instr(rand_op(), rand_wait(), rand_wait(), 1'($urandom));
    end
    reset_mid_mem();
    tick();
    do_start();
    for (int i = 0; i < 5; i++) run_instr(alu_ops[$urandom_range(0, 10)], 0, 0, 1'b0);
    run_halt(1);
    do_reset();
    do_start();
    run_instr(kBNE, 1, 0, 1'b1);
    run_timeout(1'b0);
    do_reset();
    do_start();
    run_timeout(1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
